// File: rtl/dcache_ctrl_if.sv
// Bundle of the processor-side and memory-side signals of the data cache controller.
// Handshake: a proc request is accepted in the cycle proc_stall is low; a mem request stays high until the one-cycle mem_ready.
interface dcache_ctrl_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller (hits in-cycle, miss FSM).
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl #(
  parameter int INDEX_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  dcache_ctrl_if.slave       bus,
  output logic [1:0]         state_dbg
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);
  localparam int TAG_W = 28 - INDEX_W;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NBLK-1:0]  valid_q;
  logic [NBLK-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [NBLK];
  logic [127:0]     data_q [NBLK];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [1:0]         off;
  logic               req;
  logic               hit;
  logic               write_hit;
  logic               refill;

  assign idx       = bus.proc_addr[INDEX_W+1:2];
  assign addr_tag  = bus.proc_addr[29:INDEX_W+2];
  assign off       = bus.proc_addr[1:0];
  assign req       = bus.proc_read | bus.proc_write;
  assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign write_hit = (state == COMPARE) && bus.proc_write && hit;
  assign refill    = (state == ALLOCATE) && bus.mem_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= COMPARE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COMPARE: begin
        if (req && !hit)
          state_next = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: if (bus.mem_ready) state_next = ALLOCATE;
      ALLOCATE:  if (bus.mem_ready) state_next = COMPARE;
      default:   state_next = COMPARE;
    endcase
  end

  // mem_read/mem_write come only from the state register so they cannot glitch or overlap.
  always_comb begin
    bus.proc_stall = req && !((state == COMPARE) && hit);
    bus.proc_rdata = ((state == COMPARE) && hit) ? data_q[idx][{off, 5'b0} +: 32] : 32'd0;
    bus.mem_write  = (state == WRITEBACK);
    bus.mem_read   = (state == ALLOCATE);
    bus.mem_wdata  = data_q[idx];
    bus.mem_addr   = bus.proc_addr[29:2];
    if (state == WRITEBACK) bus.mem_addr = {tag_q[idx], idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end else if (refill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= bus.proc_wdata;
    end else if (refill) begin
      data_q[idx] <= bus.mem_rdata;
      tag_q[idx]  <= addr_tag;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic refill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      refill_q <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      refill_q <= refill;
      if ((state == COMPARE) && req && !hit && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
      if ((state == COMPARE) && req && hit && !refill_q && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
    end
  end
`endif
endmodule
